ddr3_pix_gearbox: RTL and testbench



---
 rtl/ddr3_pix_gearbox.sv | 186 ++++++++++++++++++
 tb/tb_ddr3_pix_gearbox.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pix_gearbox.sv
// Pixel <-> bus-word gearbox for the DDR3 frame path: packs PIX_W pixels into BUS_W
// words toward the write FIFO, and unpacks read-FIFO words back into a pixel stream.
module ddr3_pix_gearbox #(
   parameter int PIX_W     = 16,
   parameter int BUS_W     = 256,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk_100,
   input  logic             rst_n,
   input  logic             wr_load,
   input  logic             wr_flush,
   input  logic             pix_in_valid,
   input  logic [PIX_W-1:0] pix_in,
   output logic             pix_in_ready,
   output logic [BUS_W-1:0] wword,
   output logic             wword_valid,
   input  logic             wword_ready,
   input  logic             rd_load,
   input  logic [BUS_W-1:0] rword,
   input  logic             rword_valid,
   output logic             rword_ready,
   input  logic             pix_req,
   output logic [PIX_W-1:0] pix_out,
   output logic             pix_out_valid,
   output logic             underrun,
   output logic             underrun_sticky
);

   localparam int N  = BUS_W / PIX_W;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   function automatic int lane_lo(input logic [CW-1:0] k);
      return (MSB_FIRST != 0) ? BUS_W - PIX_W * (int'(k) + 1) : PIX_W * int'(k);
   endfunction

   function automatic logic [PIX_W-1:0] lane_get(input logic [BUS_W-1:0] w,
                                                 input logic [CW-1:0] k);
      return w[lane_lo(k) +: PIX_W];
   endfunction

   function automatic logic [BUS_W-1:0] lane_put(input logic [BUS_W-1:0] w,
                                                 input logic [CW-1:0] k,
                                                 input logic [PIX_W-1:0] p);
      logic [BUS_W-1:0] r;
      r = w;
      r[lane_lo(k) +: PIX_W] = p;
      return r;
   endfunction

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BUS_W-1:0] asm_q, asm_d;
   logic [BUS_W-1:0] wword_q, wword_d;
   logic             wword_valid_q, wword_valid_d;
   logic             flush_pend_q, flush_pend_d;
   logic             out_free, accept, complete;

   logic [BUS_W-1:0] cur_q, cur_d, nxt_q, nxt_d;
   logic             cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [PIX_W-1:0] pix_out_q, pix_out_d;
   logic             pix_out_valid_q, pix_out_valid_d;
   logic             underrun_q, underrun_d;
   logic             sticky_q, sticky_d;
   logic             racc, serve, retire;

   // Packer: writing lane 0 starts a fresh word, so unfilled lanes are always zero on flush
   always_comb begin
      out_free      = !wword_valid_q || wword_ready;
      pix_in_ready  = !flush_pend_q && (cnt_q != LAST || out_free);
      accept        = pix_in_valid && pix_in_ready;
      complete      = accept && (cnt_q == LAST);
      cnt_d         = cnt_q;
      asm_d         = asm_q;
      wword_d       = wword_q;
      wword_valid_d = wword_valid_q && !wword_ready;
      flush_pend_d  = flush_pend_q;
      if (accept) begin
         asm_d = lane_put((cnt_q == '0) ? {BUS_W{1'b0}} : asm_q, cnt_q, pix_in);
         cnt_d = cnt_q + 1'b1;
      end
      if (complete) begin
         wword_d       = asm_d;
         wword_valid_d = 1'b1;
      end
      if (wr_flush && cnt_d != '0) flush_pend_d = 1'b1;
      if (flush_pend_q && out_free) begin
         wword_d       = asm_q;
         wword_valid_d = 1'b1;
         cnt_d         = '0;
         flush_pend_d  = 1'b0;
      end
      if (wr_load) begin
         cnt_d         = '0;
         flush_pend_d  = 1'b0;
         wword_valid_d = 1'b0;
      end
   end

   // Unpacker: nxt prefetches the following word so lane N-1 -> lane 0 has no bubble
   always_comb begin
      rword_ready     = !nxt_v_q && !rd_load;
      racc            = rword_valid && rword_ready;
      serve           = pix_req && cur_v_q;
      retire          = serve && (idx_q == LAST);
      cur_d           = cur_q;
      cur_v_d         = cur_v_q;
      nxt_d           = nxt_q;
      nxt_v_d         = nxt_v_q;
      idx_d           = idx_q;
      pix_out_d       = pix_out_q;
      pix_out_valid_d = 1'b0;
      underrun_d      = pix_req && !cur_v_q;
      sticky_d        = sticky_q || underrun_d;
      if (serve) begin
         pix_out_d       = lane_get(cur_q, idx_q);
         pix_out_valid_d = 1'b1;
         idx_d           = idx_q + 1'b1;
      end
      if (retire) begin
         cur_d   = nxt_q;
         cur_v_d = nxt_v_q;
         nxt_v_d = 1'b0;
      end
      if (racc) begin
         if (!cur_v_q || retire) begin
            cur_d   = rword;
            cur_v_d = 1'b1;
         end else begin
            nxt_d   = rword;
            nxt_v_d = 1'b1;
         end
      end
      if (rd_load) begin
         cur_v_d         = 1'b0;
         nxt_v_d         = 1'b0;
         idx_d           = '0;
         pix_out_valid_d = 1'b0;
         underrun_d      = 1'b0;
         sticky_d        = 1'b0;
      end
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q           <= '0;
         wword_q         <= '0;
         wword_valid_q   <= 1'b0;
         flush_pend_q    <= 1'b0;
         cur_v_q         <= 1'b0;
         nxt_v_q         <= 1'b0;
         idx_q           <= '0;
         pix_out_q       <= '0;
         pix_out_valid_q <= 1'b0;
         underrun_q      <= 1'b0;
         sticky_q        <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         wword_q         <= wword_d;
         wword_valid_q   <= wword_valid_d;
         flush_pend_q    <= flush_pend_d;
         cur_v_q         <= cur_v_d;
         nxt_v_q         <= nxt_v_d;
         idx_q           <= idx_d;
         pix_out_q       <= pix_out_d;
         pix_out_valid_q <= pix_out_valid_d;
         underrun_q      <= underrun_d;
         sticky_q        <= sticky_d;
      end
   end

   // Word buffers are qualified by cnt/cur_v/nxt_v and never need a reset value
   always_ff @(posedge clk_100) begin
      asm_q <= asm_d;
      cur_q <= cur_d;
      nxt_q <= nxt_d;
   end

   assign wword           = wword_q;
   assign wword_valid     = wword_valid_q;
   assign pix_out         = pix_out_q;
   assign pix_out_valid   = pix_out_valid_q;
   assign underrun        = underrun_q;
   assign underrun_sticky = sticky_q;

endmodule

// File: tb/tb_ddr3_pix_gearbox.sv
// Scoreboard bench for ddr3_pix_gearbox: an MSB-first and an LSB-first instance share
// all stimulus; expected words/pixels are queued when stimulus is accepted.
module tb_ddr3_pix_gearbox;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_load = 1'b0, wr_flush = 1'b0, pix_in_valid = 1'b0;
   logic [15:0]  pix_in = '0;
   logic         wword_ready = 1'b1;
   logic         rd_load = 1'b0, rword_valid = 1'b0, pix_req = 1'b0;
   logic [255:0] rword = '0;

   logic         m_pr, m_wv, m_rr, m_pv, m_un, m_us;
   logic [255:0] m_ww;
   logic [15:0]  m_po;
   logic         l_pr, l_wv, l_rr, l_pv, l_un, l_us;
   logic [255:0] l_ww;
   logic [15:0]  l_po;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ddr3_pix_gearbox #(.PIX_W(16), .BUS_W(256), .MSB_FIRST(1)) u_msb (
      .clk_100(clk), .rst_n(rst_n), .wr_load(wr_load), .wr_flush(wr_flush),
      .pix_in_valid(pix_in_valid), .pix_in(pix_in), .pix_in_ready(m_pr),
      .wword(m_ww), .wword_valid(m_wv), .wword_ready(wword_ready),
      .rd_load(rd_load), .rword(rword), .rword_valid(rword_valid), .rword_ready(m_rr),
      .pix_req(pix_req), .pix_out(m_po), .pix_out_valid(m_pv),
      .underrun(m_un), .underrun_sticky(m_us));

   ddr3_pix_gearbox #(.PIX_W(16), .BUS_W(256), .MSB_FIRST(0)) u_lsb (
      .clk_100(clk), .rst_n(rst_n), .wr_load(wr_load), .wr_flush(wr_flush),
      .pix_in_valid(pix_in_valid), .pix_in(pix_in), .pix_in_ready(l_pr),
      .wword(l_ww), .wword_valid(l_wv), .wword_ready(wword_ready),
      .rd_load(rd_load), .rword(rword), .rword_valid(rword_valid), .rword_ready(l_rr),
      .pix_req(pix_req), .pix_out(l_po), .pix_out_valid(l_pv),
      .underrun(l_un), .underrun_sticky(l_us));

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   logic [255:0] expq_m[$], expq_l[$], wq[$];
   logic [15:0]  pq_m[$], pq_l[$];
   logic [15:0]  lanes[16];
   int           mcnt = 0;
   int           vcyc = 0;
   int           pvcnt = 0;
   logic [255:0] last_m = '0, last_l = '0;

   task automatic push_model();
      logic [255:0] em, el;
      em = '0;
      el = '0;
      for (int k = 0; k < 16; k++) begin
         if (k < mcnt) begin
            em[255 - 16*k -: 16] = lanes[k];
            el[16*k +: 16]       = lanes[k];
         end
      end
      expq_m.push_back(em);
      expq_l.push_back(el);
      mcnt = 0;
   endtask

   task automatic send_pix(input logic [15:0] p);
      bit ok;
      ok = 1'b0;
      pix_in_valid = 1'b1;
      pix_in = p;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_pr) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("pix_in_ready_timeout", 0, 1);
      else begin
         lanes[mcnt] = p;
         mcnt++;
         if (mcnt == 16) push_model();
      end
      @(posedge clk);
      #1;
      pix_in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk_word(input logic [15:0] base);
      logic [255:0] w;
      for (int k = 0; k < 16; k++) w[16*k +: 16] = base + 16'(k);
      return w;
   endfunction

   // word-side monitor: a transfer happens at the next posedge
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_wv) vcyc++;
         if (m_wv && wword_ready) begin
            if (expq_m.size() == 0) check("pack_unexpected_word", 1, 0);
            else begin
               check("wword_msb", m_ww, expq_m.pop_front());
               check("wword_lsb", l_ww, expq_l.pop_front());
               last_m = m_ww;
               last_l = l_ww;
            end
         end
      end
   end

   // read-word acceptance: queue the pixels each instance must produce
   always @(negedge clk) begin
      if (rst_n && rword_valid && m_rr) begin
         for (int k = 0; k < 16; k++) begin
            pq_l.push_back(rword[16*k +: 16]);
            pq_m.push_back(rword[255 - 16*k -: 16]);
         end
         void'(wq.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && m_pv) begin
         pvcnt++;
         if (pq_m.size() == 0) check("pix_unexpected", 1, 0);
         else begin
            check("pix_out_msb", m_po, pq_m.pop_front());
            check("pix_out_lsb", l_po, pq_l.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rword_valid = (wq.size() != 0);
         rword = (wq.size() != 0) ? wq[0] : '0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout got %0d exp %0d", 1, 0);
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 16; k++) lanes[k] = '0;
      #22 rst_n = 1'b1;
      @(negedge clk);
      check("rst_wword", m_ww, 0);
      check("rst_wword_valid", m_wv, 0);
      check("rst_pix_out", m_po, 0);
      check("rst_pix_out_valid", m_pv, 0);
      check("rst_underrun", m_un, 0);
      check("rst_sticky", m_us, 0);
      check("rst_pix_in_ready", m_pr, 1);
      check("rst_rword_ready", m_rr, 1);
      cycles(1);

      // pack, back-to-back pixels 1..16
      vcyc = 0;
      for (int i = 1; i <= 16; i++) send_pix(16'(i));
      cycles(4);
      check("pack_msb_first_lane", last_m[255:240], 16'h0001);
      check("pack_msb_last_lane", last_m[15:0], 16'h0010);
      check("pack_lsb_first_lane", last_l[15:0], 16'h0001);
      check("wword_valid_cycles", vcyc, 1);

      // back-pressure: 31 pixels fit, the 32nd stalls
      wword_ready = 1'b0;
      for (int i = 1; i <= 31; i++) send_pix(16'h0100 + 16'(i));
      pix_in_valid = 1'b1;
      pix_in = 16'h0120;
      @(negedge clk);
      check("bp_ready_low", m_pr, 0);
      cycles(2);
      check("bp_ready_still_low", m_pr, 0);
      check("bp_word_held", m_wv, 1);
      wword_ready = 1'b1;
      send_pix(16'h0120);
      cycles(4);
      check("bp_words_drained", expq_m.size(), 0);

      // partial flush after 5 pixels
      for (int i = 1; i <= 5; i++) send_pix(16'h0200 + 16'(i));
      wr_flush = 1'b1;
      push_model();
      cycles(1);
      wr_flush = 1'b0;
      cycles(4);
      check("flush_lane0", last_m[255:240], 16'h0201);
      check("flush_zero_lanes", last_m[175:0], 0);
      check("flush_drained", expq_m.size(), 0);

      // wr_load after 7 pixels discards them
      for (int i = 1; i <= 7; i++) send_pix(16'(i));
      wr_load = 1'b1;
      mcnt = 0;
      cycles(1);
      wr_load = 1'b0;
      for (int i = 8; i <= 23; i++) send_pix(16'(i));
      cycles(4);
      check("wrload_first", last_m[255:240], 16'h0008);
      check("wrload_last", last_m[15:0], 16'h0017);
      check("wrload_drained", expq_m.size(), 0);

      // continuous unpack: 3 words, 48 requests, no bubbles
      pvcnt = 0;
      for (int i = 0; i < 3; i++) wq.push_back(mk_word(16'h0001));
      cycles(2);
      pix_req = 1'b1;
      cycles(48);
      pix_req = 1'b0;
      cycles(3);
      check("stream_pix_count", pvcnt, 48);
      check("stream_no_underrun", m_us, 0);
      check("stream_drained", pq_m.size(), 0);

      // underrun with no data
      pix_req = 1'b1;
      cycles(1);
      pix_req = 1'b0;
      @(negedge clk);
      check("ur_pulse", m_un, 1);
      check("ur_sticky", m_us, 1);
      check("ur_no_valid", m_pv, 0);
      @(negedge clk);
      check("ur_pulse_end", m_un, 0);
      check("ur_sticky_held", m_us, 1);
      cycles(1);
      rd_load = 1'b1;
      cycles(1);
      rd_load = 1'b0;
      @(negedge clk);
      check("ur_sticky_cleared", m_us, 0);

      // rd_load mid-word restarts at lane 0 of the next word
      wq.push_back(mk_word(16'h0020));
      cycles(3);
      pix_req = 1'b1;
      cycles(3);
      pix_req = 1'b0;
      cycles(3);
      rd_load = 1'b1;
      pq_m.delete();
      pq_l.delete();
      cycles(1);
      rd_load = 1'b0;
      wq.push_back(mk_word(16'h0040));
      cycles(3);
      pix_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rdload_lane0_lsb", l_po, 16'h0040);
      check("rdload_lane0_msb", m_po, 16'h004f);
      cycles(15);
      pix_req = 1'b0;
      cycles(3);
      check("rdload_drained", pq_m.size(), 0);

      // async reset mid-stream
      wword_ready = 1'b0;
      for (int i = 1; i <= 16; i++) send_pix(16'h0300 + 16'(i));
      pix_in_valid = 1'b1;
      pix_in = 16'h0399;
      pix_req = 1'b1;
      cycles(2);
      check("pre_rst_word_held", m_wv, 1);
      check("pre_rst_sticky", m_us, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_wword", m_ww, 0);
      check("arst_wword_valid", m_wv, 0);
      check("arst_pix_out", m_po, 0);
      check("arst_pix_out_valid", m_pv, 0);
      check("arst_underrun", m_un, 0);
      check("arst_sticky", m_us, 0);
      check("arst_lsb_wword", l_ww, 0);
      check("arst_pix_in_ready", m_pr, 1);
      pix_in_valid = 1'b0;
      pix_req = 1'b0;
      wword_ready = 1'b1;
      expq_m.delete();
      expq_l.delete();
      mcnt = 0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      cycles(3);
      check("post_rst_idle", m_wv, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
